led_chain_driver: RTL and testbench

- Drives a chain of NUM_LEDS WS2812B LEDs from a per-LED on/off vector.
- Each LED shows ON_COLOR or OFF_COLOR.
- Contains its own frame sequencer and 800 kHz bit serializer, including bit timing and the latch/reset gap.
- Successor to the single-LED constant-colour driver; sits between front-panel/status logic and the LED strip pin.

---
 rtl/led_chain_driver.sv | 210 +++++++++++++++++++++
 tb/tb_led_chain_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chain_driver.sv
// led_chain_driver
//   Drives a chain of NUM_LEDS WS2812B LEDs from a per-LED on/off vector.
//   Each LED is sent ON_COLOR (data bit 1) or OFF_COLOR (data bit 0),
//   24 bits per LED in wire order {G,R,B}, MSB first, LED 0 first.
//   An 80-us (RESET_US) low gap follows every frame to latch the strip.
//
// Ports
//   clk          system clock (CLK_FREQ Hz)
//   rst          asynchronous reset, active-low
//   ready        while high, frames are latched and transmitted continuously
//   data         on/off per LED, bit 0 = first LED in the chain
//   brightness   [7:0] global scale, latched with data (optional, see macro)
//   busy         high from latch until the end of the reset gap
//   data_latched one-cycle pulse on each new snapshot of data
//   led_out      WS2812B serial line (registered)
//
// Build option
//   LED_CHAIN_BRIGHTNESS_EN : adds the brightness port; each colour channel
//                             is sent as (c*(brightness+1))>>8.
module led_chain_driver #(
    parameter int unsigned CLK_FREQ  = 27_000_000,
    parameter int unsigned NUM_LEDS  = 8,
    parameter logic [23:0] ON_COLOR  = 24'h00ff00,
    parameter logic [23:0] OFF_COLOR = 24'h000000,
    parameter int unsigned RESET_US  = 80
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ready,
    input  logic [NUM_LEDS-1:0] data,
`ifdef LED_CHAIN_BRIGHTNESS_EN
    input  logic [7:0]          brightness,
`endif
    output logic                busy,
    output logic                data_latched,
    output logic                led_out
);

    localparam int unsigned BIT_CYC = CLK_FREQ / 800_000;
    localparam int unsigned T0H     = CLK_FREQ * 2 / 5_000_000;
    localparam int unsigned T1H     = CLK_FREQ * 4 / 5_000_000;
    localparam int unsigned RST_CYC = CLK_FREQ / 1_000_000 * RESET_US;
    localparam int unsigned NBITS   = NUM_LEDS * 24;
    localparam int unsigned CNT_MAX = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam int unsigned BW      = $clog2(NBITS);
    localparam int unsigned LW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] T0H_C     = CW'(T0H);
    localparam logic [CW-1:0] T1H_C     = CW'(T1H);
    localparam logic [BW-1:0] BIDX_LAST = BW'(NBITS - 1);

    if (T1H >= BIT_CYC || T0H == 0 || NUM_LEDS < 1) begin : g_param_check
        $error("led_chain_driver: invalid CLK_FREQ timing or NUM_LEDS");
    end

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cyc, cyc_nxt;
    logic [BW-1:0]       bit_idx, bit_idx_nxt;
    logic [LW-1:0]       led_idx, led_idx_nxt;
    logic [4:0]          bit_pos, bit_pos_nxt;
    logic [NUM_LEDS-1:0] snapshot, snap_nxt;
    logic                chain, chain_nxt;
    logic                led_nxt, busy_nxt, latched_nxt;
    logic [CW-1:0]       cyc_inc;
    logic [23:0]         on_c, off_c, colour;
    logic                cur_bit;

`ifdef LED_CHAIN_BRIGHTNESS_EN
    logic [7:0] bright_q, bright_nxt;

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return 8'(p >> 8);
    endfunction

    function automatic logic [23:0] scale_rgb(input logic [23:0] col, input logic [7:0] b);
        return {scale_ch(col[23:16], b), scale_ch(col[15:8], b), scale_ch(col[7:0], b)};
    endfunction

    assign on_c  = scale_rgb(ON_COLOR, bright_q);
    assign off_c = scale_rgb(OFF_COLOR, bright_q);
`else
    assign on_c  = ON_COLOR;
    assign off_c = OFF_COLOR;
`endif

    assign colour  = snapshot[led_idx] ? on_c : off_c;
    assign cur_bit = colour[bit_pos];
    assign cyc_inc = cyc + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cyc          <= '0;
            bit_idx      <= '0;
            led_idx      <= '0;
            bit_pos      <= '0;
            snapshot     <= '0;
            chain        <= 1'b0;
            busy         <= 1'b0;
            data_latched <= 1'b0;
            led_out      <= 1'b0;
`ifdef LED_CHAIN_BRIGHTNESS_EN
            bright_q     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            cyc          <= cyc_nxt;
            bit_idx      <= bit_idx_nxt;
            led_idx      <= led_idx_nxt;
            bit_pos      <= bit_pos_nxt;
            snapshot     <= snap_nxt;
            chain        <= chain_nxt;
            busy         <= busy_nxt;
            data_latched <= latched_nxt;
            led_out      <= led_nxt;
`ifdef LED_CHAIN_BRIGHTNESS_EN
            bright_q     <= bright_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc;
        bit_idx_nxt = bit_idx;
        led_idx_nxt = led_idx;
        bit_pos_nxt = bit_pos;
        snap_nxt    = snapshot;
        chain_nxt   = 1'b0;
        led_nxt     = 1'b0;
        latched_nxt = 1'b0;
`ifdef LED_CHAIN_BRIGHTNESS_EN
        bright_nxt  = bright_q;
`endif
        case (state)
            S_IDLE: begin
                if (ready) begin
                    snap_nxt    = data;
`ifdef LED_CHAIN_BRIGHTNESS_EN
                    bright_nxt  = brightness;
`endif
                    state_nxt   = S_SEND;
                    cyc_nxt     = '0;
                    bit_idx_nxt = '0;
                    led_idx_nxt = '0;
                    bit_pos_nxt = 5'd23;
                    led_nxt     = 1'b1;
                    latched_nxt = 1'b1;
                end
            end
            S_SEND: begin
                if (cyc == BIT_LAST) begin
                    cyc_nxt = '0;
                    if (bit_idx == BIDX_LAST) begin
                        state_nxt = S_GAP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        if (bit_pos == 5'd0) begin
                            bit_pos_nxt = 5'd23;
                            led_idx_nxt = led_idx + 1'b1;
                        end else begin
                            bit_pos_nxt = bit_pos - 5'd1;
                        end
                        // every bit starts with its high phase
                        led_nxt = 1'b1;
                    end
                end else begin
                    cyc_nxt = cyc_inc;
                    led_nxt = cur_bit ? (cyc_inc < T1H_C) : (cyc_inc < T0H_C);
                end
            end
            S_GAP: begin
                if (chain) begin
                    // Hold cycle after a back-to-back re-latch: stands in for
                    // the IDLE sample cycle so the latch-to-latch period is
                    // 1 + NBITS*BIT_CYC + RST_CYC without dropping busy.
                    state_nxt   = S_SEND;
                    cyc_nxt     = '0;
                    bit_idx_nxt = '0;
                    led_idx_nxt = '0;
                    bit_pos_nxt = 5'd23;
                    led_nxt     = 1'b1;
                    latched_nxt = 1'b1;
                end else if (cyc == RST_LAST) begin
                    if (ready) begin
                        snap_nxt   = data;
`ifdef LED_CHAIN_BRIGHTNESS_EN
                        bright_nxt = brightness;
`endif
                        chain_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cyc_nxt = cyc_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_led_chain_driver.sv
module tb_led_chain_driver;

    localparam int unsigned NL = 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          ready = 1'b0;
    logic [NL-1:0] data  = '0;
`ifdef LED_CHAIN_BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd255;
`endif
    logic          busy, data_latched, led_out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_chain_driver #(
        .CLK_FREQ (27_000_000),
        .NUM_LEDS (NL),
        .ON_COLOR (24'h00ff00),
        .OFF_COLOR(24'h000000),
        .RESET_US (80)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .data        (data),
`ifdef LED_CHAIN_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .busy        (busy),
        .data_latched(data_latched),
        .led_out     (led_out)
    );

    // Returns at the negedge on which data_latched is first seen high.
    task automatic wait_latch(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (data_latched) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Samples 48 bit periods of 33 cycles starting at the current negedge
    // (first SEND cycle); bits[47:24] is LED 0. Returns on the last SEND cycle.
    task automatic grab_frame(input int chg_bit, input logic [NL-1:0] chg_val,
                              input int drop_bit, output logic [47:0] bits,
                              output int bad, output int busy_cnt, output int lat_cnt);
        int   ones;
        logic prev;
        logic shape_ok;
        bits = '0; bad = 0; busy_cnt = 0; lat_cnt = 0;
        ones = 0; prev = 1'b1; shape_ok = 1'b1;
        for (int k = 0; k < 48 * 33; k++) begin
            int b;
            int c;
            b = k / 33;
            c = k % 33;
            if (c == 0) begin
                if (b == chg_bit) data = chg_val;
                if (b == drop_bit) ready = 1'b0;
                ones = 0; prev = 1'b1; shape_ok = 1'b1;
            end
            if (busy) busy_cnt++;
            if (data_latched) lat_cnt++;
            if (led_out) begin
                ones++;
                if (!prev) shape_ok = 1'b0;
            end
            prev = led_out;
            if (c == 32) begin
                bits[47 - b] = (ones == 21);
                if (!shape_ok || (ones != 21 && ones != 10)) bad++;
            end
            if (k < 48 * 33 - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (led_out !== 1'b0) begin miscompares++; $display("FAIL reset_led: got %b want 0", led_out); end
        vectors++; if (data_latched !== 1'b0) begin miscompares++; $display("FAIL reset_latched: got %b want 0", data_latched); end
        rst = 1'b1;
    endtask

    task automatic test_idle;
        int led_hi = 0, busy_hi = 0, lat = 0;
        ready = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (led_out) led_hi++;
            if (busy) busy_hi++;
            if (data_latched) lat++;
        end
        vectors++; if (led_hi !== 0) begin miscompares++; $display("FAIL idle_led: got %0d high cycles want 0", led_hi); end
        vectors++; if (busy_hi !== 0) begin miscompares++; $display("FAIL idle_busy: got %0d busy cycles want 0", busy_hi); end
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL idle_latch: got %0d pulses want 0", lat); end
    endtask

    task automatic test_single_frame;
        bit seen;
        logic [47:0] bits;
        int bad, busy_cnt, lat_cnt, gap, led_err, lat;
        data = 2'b01; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        wait_latch(5, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL single_latch: got %b want 1", seen); end
        grab_frame(-1, '0, -1, bits, bad, busy_cnt, lat_cnt);
        vectors++; if (bits !== 48'h00FF00_000000) begin miscompares++; $display("FAIL single_bits: got %h want %h", bits, 48'h00FF00_000000); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL single_timing: got %0d bad bits want 0", bad); end
        vectors++; if (busy_cnt !== 1584) begin miscompares++; $display("FAIL single_busy_send: got %0d want 1584", busy_cnt); end
        vectors++; if (lat_cnt !== 1) begin miscompares++; $display("FAIL single_pulse: got %0d want 1", lat_cnt); end
        gap = 0; led_err = 0; lat = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (!busy) break;
            gap++;
            if (led_out) led_err++;
            if (data_latched) lat++;
        end
        vectors++; if (gap !== 2160) begin miscompares++; $display("FAIL single_gap: got %0d want 2160", gap); end
        vectors++; if (led_err !== 0) begin miscompares++; $display("FAIL single_gap_led: got %0d high want 0", led_err); end
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL single_gap_latch: got %0d want 0", lat); end
    endtask

    task automatic test_back_to_back;
        bit seen, got;
        logic [47:0] bits;
        int bad, busy_cnt, lat_cnt, n, idle;
        repeat (5) @(negedge clk);
        data = 2'b01; ready = 1'b1;
        wait_latch(5, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL b2b_latch: got %b want 1", seen); end
        grab_frame(5, 2'b10, -1, bits, bad, busy_cnt, lat_cnt);
        vectors++; if (bits !== 48'h00FF00_000000) begin miscompares++; $display("FAIL b2b_frame1: got %h want %h", bits, 48'h00FF00_000000); end
        n = 1583; idle = 0; got = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            n++;
            if (!busy) idle++;
            if (data_latched) begin got = 1'b1; break; end
        end
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL b2b_relatch: got %b want 1", got); end
        vectors++; if (n !== 3745) begin miscompares++; $display("FAIL b2b_period: got %0d want 3745", n); end
        vectors++; if (idle !== 0) begin miscompares++; $display("FAIL b2b_idle: got %0d idle cycles want 0", idle); end
        ready = 1'b0;
        grab_frame(-1, '0, -1, bits, bad, busy_cnt, lat_cnt);
        vectors++; if (bits !== 48'h000000_00FF00) begin miscompares++; $display("FAIL b2b_frame2: got %h want %h", bits, 48'h000000_00FF00); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_timing: got %0d bad bits want 0", bad); end
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end: busy got %b want 0", busy); end
    endtask

    task automatic test_ready_drop;
        bit seen;
        logic [47:0] bits;
        int bad, busy_cnt, lat_cnt, gap, lat, busy_after;
        repeat (5) @(negedge clk);
        data = 2'b11; ready = 1'b1;
        wait_latch(5, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL drop_latch: got %b want 1", seen); end
        grab_frame(-1, '0, 10, bits, bad, busy_cnt, lat_cnt);
        vectors++; if (bits !== 48'h00FF00_00FF00) begin miscompares++; $display("FAIL drop_bits: got %h want %h", bits, 48'h00FF00_00FF00); end
        vectors++; if (busy_cnt !== 1584) begin miscompares++; $display("FAIL drop_busy_send: got %0d want 1584", busy_cnt); end
        gap = 0; lat = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (!busy) break;
            gap++;
            if (data_latched) lat++;
        end
        vectors++; if (gap !== 2160) begin miscompares++; $display("FAIL drop_gap: got %0d want 2160", gap); end
        busy_after = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (data_latched) lat++;
            if (busy) busy_after++;
        end
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL drop_no_latch: got %0d want 0", lat); end
        vectors++; if (busy_after !== 0) begin miscompares++; $display("FAIL drop_idle_busy: got %0d want 0", busy_after); end
    endtask

    task automatic test_async_reset;
        bit seen;
        logic [47:0] bits;
        int bad, busy_cnt, lat_cnt;
        repeat (5) @(negedge clk);
        data = 2'b01; ready = 1'b1;
        wait_latch(5, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL areset_latch: got %b want 1", seen); end
        repeat (200) @(negedge clk);
        vectors++; if ({led_out, busy} !== 2'b11) begin miscompares++; $display("FAIL areset_pre: got %b want 11", {led_out, busy}); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (led_out !== 1'b0) begin miscompares++; $display("FAIL areset_led: got %b want 0", led_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", busy); end
        vectors++; if (data_latched !== 1'b0) begin miscompares++; $display("FAIL areset_latched: got %b want 0", data_latched); end
        @(negedge clk);
        data = 2'b10;
        @(negedge clk);
        vectors++; if ({led_out, busy, data_latched} !== 3'b000) begin miscompares++; $display("FAIL areset_hold: got %b want 000", {led_out, busy, data_latched}); end
        rst = 1'b1;
        wait_latch(5, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL areset_restart: got %b want 1", seen); end
        grab_frame(-1, '0, 0, bits, bad, busy_cnt, lat_cnt);
        vectors++; if (bits !== 48'h000000_00FF00) begin miscompares++; $display("FAIL areset_bits: got %h want %h", bits, 48'h000000_00FF00); end
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

`ifdef LED_CHAIN_BRIGHTNESS_EN
    task automatic test_brightness;
        bit seen;
        logic [47:0] bits;
        int bad, busy_cnt, lat_cnt;
        repeat (5) @(negedge clk);
        data = 2'b11; brightness = 8'd127; ready = 1'b1;
        wait_latch(5, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL bright_latch: got %b want 1", seen); end
        brightness = 8'd0;
        grab_frame(-1, '0, -1, bits, bad, busy_cnt, lat_cnt);
        vectors++; if (bits !== 48'h007F00_007F00) begin miscompares++; $display("FAIL bright_127: got %h want %h", bits, 48'h007F00_007F00); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bright_timing: got %0d bad bits want 0", bad); end
        seen = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (data_latched) begin seen = 1'b1; break; end
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL bright_relatch: got %b want 1", seen); end
        grab_frame(-1, '0, 0, bits, bad, busy_cnt, lat_cnt);
        vectors++; if (bits !== 48'h0) begin miscompares++; $display("FAIL bright_0: got %h want %h", bits, 48'h0); end
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_single_frame();
        test_back_to_back();
        test_ready_drop();
        test_async_reset();
`ifdef LED_CHAIN_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
